// File: rtl/register_file_pkg.sv
// ============================================================================
// register_file_pkg : shared types and default sizing for the register file.
// Revision: 1.0
// ============================================================================
`default_nettype none

package register_file_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage : register_file_pkg

`default_nettype wire

// File: rtl/register_file_clear_sequencer.sv
// ============================================================================
// clear_sequencer : walks an index over every register, one per cycle, when
// a bulk clear is requested; busy_o covers the whole walk.
// Revision: 1.0
// ============================================================================
`default_nettype none

module clear_sequencer
  import register_file_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  output logic          busy_o,
  output logic          clr_stb_o,
  output logic [AW-1:0] clr_idx_o
);

  localparam logic [AW-1:0] C_LAST_IDX = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_stb_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        clr_stb_o = 1'b1;
        // Park the counter at zero on exit instead of letting it wrap.
        if (cnt_q == C_LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o    = (state_q == CLEAR);
  assign clr_idx_o = cnt_q;

endmodule : clear_sequencer

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// register_file : DEPTH x WIDTH register file, one write port, two
// combinational read ports, per-register written flags and a sequenced bulk
// clear. Define REGISTER_FILE_BYPASS_EN to forward accepted write data to a
// read port addressing the register being written in the same cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             enable,
  input  logic [AW-1:0]    write_addr,
  input  logic [AW-1:0]    read_addr_a,
  input  logic [AW-1:0]    read_addr_b,
  input  logic             clear,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             busy,
  output logic [DEPTH-1:0] written
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] written_q;

  logic          w_clr_stb;
  logic [AW-1:0] w_clr_idx;
  logic          w_busy;
  logic          w_we;

  clear_sequencer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_sequencer (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .clear_i   (clear),
    .busy_o    (w_busy),
    .clr_stb_o (w_clr_stb),
    .clr_idx_o (w_clr_idx)
  );

  // A clear request on the same edge as a write takes priority over it.
  assign w_we = enable && !w_busy && !clear;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      written_q <= '0;
    end else if (w_clr_stb) begin
      mem_q[w_clr_idx]     <= '0;
      written_q[w_clr_idx] <= 1'b0;
    end else if (w_we) begin
      mem_q[write_addr]     <= in;
      written_q[write_addr] <= 1'b1;
    end
  end

`ifdef REGISTER_FILE_BYPASS_EN
  assign out_a = (w_we && (read_addr_a == write_addr)) ? in : mem_q[read_addr_a];
  assign out_b = (w_we && (read_addr_b == write_addr)) ? in : mem_q[read_addr_b];
`else
  assign out_a = mem_q[read_addr_a];
  assign out_b = mem_q[read_addr_b];
`endif

  assign busy    = w_busy;
  assign written = written_q;

endmodule : register_file

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// tb_register_file : directed vector table plus hand-written clear/reset
// sequences for register_file at WIDTH=16, DEPTH=8.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_register_file;

  logic        clock;
  logic        reset_n;
  logic [15:0] in;
  logic        enable;
  logic [2:0]  write_addr;
  logic [2:0]  read_addr_a;
  logic [2:0]  read_addr_b;
  logic        clear;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic        busy;
  logic [7:0]  written;

  int total = 0;
  int bad   = 0;

  register_file #(
    .WIDTH (16),
    .DEPTH (8)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in          (in),
    .enable      (enable),
    .write_addr  (write_addr),
    .read_addr_a (read_addr_a),
    .read_addr_b (read_addr_b),
    .clear       (clear),
    .out_a       (out_a),
    .out_b       (out_b),
    .busy        (busy),
    .written     (written)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic [2:0]  wa;
    logic [15:0] d;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [7:0]  ew;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    enable = 1'b1; write_addr = a; in = d;
    tick();
    enable = 1'b0;
  endtask

  initial begin
    logic [7:0]  exp_w;
    logic [15:0] exp_b;

    vecs[0] = '{1'b1, 3'd3, 16'd45,    3'd3, 3'd0, 16'd45,    16'd0,     8'h08};
    vecs[1] = '{1'b0, 3'd3, 16'd5,     3'd3, 3'd3, 16'd45,    16'd45,    8'h08};
    vecs[2] = '{1'b1, 3'd0, 16'h1234,  3'd0, 3'd3, 16'h1234,  16'd45,    8'h09};
    vecs[3] = '{1'b1, 3'd7, 16'hFFFF,  3'd7, 3'd0, 16'hFFFF,  16'h1234,  8'h89};
    vecs[4] = '{1'b1, 3'd0, 16'h0000,  3'd0, 3'd7, 16'h0000,  16'hFFFF,  8'h89};
    vecs[5] = '{1'b0, 3'd5, 16'hAAAA,  3'd5, 3'd5, 16'h0000,  16'h0000,  8'h89};

    reset_n = 1'b0; in = '0; enable = 1'b0; write_addr = '0;
    read_addr_a = 3'd3; read_addr_b = 3'd7; clear = 1'b0;
    #2;
    chk("reset_out_a",   32'(out_a),   32'd0);
    chk("reset_out_b",   32'(out_b),   32'd0);
    chk("reset_busy",    32'(busy),    32'd0);
    chk("reset_written", 32'(written), 32'd0);
    #10 reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      enable = vecs[i].en; write_addr = vecs[i].wa; in = vecs[i].d;
      read_addr_a = vecs[i].ra; read_addr_b = vecs[i].rb;
      tick();
      chk($sformatf("vec%0d_out_a", i),   32'(out_a),   32'(vecs[i].ea));
      chk($sformatf("vec%0d_out_b", i),   32'(out_b),   32'(vecs[i].eb));
      chk($sformatf("vec%0d_written", i), 32'(written), 32'(vecs[i].ew));
    end
    enable = 1'b0;

    // Same-cycle read of a register being written.
    enable = 1'b1; write_addr = 3'd3; in = 16'd92; read_addr_a = 3'd0; read_addr_b = 3'd3;
    #1;
`ifdef REGISTER_FILE_BYPASS_EN
    chk("bypass_pre_edge_b", 32'(out_b), 32'd92);
`else
    chk("bypass_pre_edge_b", 32'(out_b), 32'd45);
`endif
    tick();
    enable = 1'b0;
    #1;
    chk("bypass_post_edge_b", 32'(out_b), 32'd92);

    // Fill, then bulk clear; a write and a re-clear attempted mid-clear must be ignored.
    for (int i = 0; i < 8; i++) write_reg(3'(i), 16'(10 + i));
    chk("fill_written", 32'(written), 32'hFF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k == 3) begin
        enable = 1'b1; write_addr = 3'd0; in = 16'd99; clear = 1'b1;
      end else begin
        enable = 1'b0; clear = 1'b0;
      end
      read_addr_a = (k > 0) ? 3'(k - 1) : 3'd0;
      read_addr_b = (k < 8) ? 3'(k) : 3'd7;
      #1;
      exp_w = 8'hFF;
      exp_w = exp_w << k;
      exp_b = (k < 8) ? 16'(10 + k) : 16'd0;
      chk($sformatf("clr%0d_busy", k),    32'(busy),    32'(k < 8));
      chk($sformatf("clr%0d_written", k), 32'(written), 32'(exp_w));
      if (k > 0) chk($sformatf("clr%0d_out_a", k), 32'(out_a), 32'd0);
      chk($sformatf("clr%0d_out_b", k), 32'(out_b), 32'(exp_b));
      if (k < 8) tick();
    end
    enable = 1'b0; clear = 1'b0;
    read_addr_a = 3'd0;
    tick();
    chk("clr_end_busy",       32'(busy),  32'd0);
    chk("clr_write_ignored",  32'(out_a), 32'd0);

    // Clear and write on the same edge: clear wins.
    write_reg(3'd2, 16'd55);
    read_addr_a = 3'd2;
    enable = 1'b1; write_addr = 3'd2; in = 16'd7; clear = 1'b1;
    tick();
    enable = 1'b0; clear = 1'b0;
    #1;
    chk("race_busy",    32'(busy),  32'd1);
    chk("race_dropped", 32'(out_a), 32'd55);
    for (int k = 0; k < 8; k++) tick();
    chk("race_reg2",    32'(out_a),   32'd0);
    chk("race_busy_end", 32'(busy),   32'd0);
    chk("race_written", 32'(written), 32'd0);

    // Reset asserted in the middle of a clear.
    for (int i = 0; i < 8; i++) write_reg(3'(i), 16'(20 + i));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick(); tick(); tick();
    read_addr_a = 3'd7; read_addr_b = 3'd5;
    #1;
    chk("midrst_pre_a", 32'(out_a), 32'd27);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy",    32'(busy),    32'd0);
    chk("midrst_written", 32'(written), 32'd0);
    chk("midrst_out_a",   32'(out_a),   32'd0);
    chk("midrst_out_b",   32'(out_b),   32'd0);
    #2 reset_n = 1'b1;
    enable = 1'b1; write_addr = 3'd4; in = 16'd77; read_addr_a = 3'd4;
    tick();
    enable = 1'b0;
    #1;
    chk("postrst_busy",    32'(busy),    32'd0);
    chk("postrst_write",   32'(out_a),   32'd77);
    chk("postrst_written", 32'(written), 32'h10);
    chk("postrst_out_b",   32'(out_b),   32'd0);
    tick();
    chk("postrst_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule : tb_register_file

`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, 16, data width of each register in bits.
REQ-002 Parameter DEPTH, 8, number of registers; power of two, >= 2.
REQ-003 Derived constant AW = clog2(DEPTH), address width.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  reset; asynchronous, active-low.
REQ-006 in  input  WIDTH  write data.
REQ-007 enable  input  1  write request, sampled on rising edge.
REQ-008 write_addr  input  AW  target register of write.
REQ-009 read_addr_a  input  AW  read port A address.
REQ-010 read_addr_b  input  AW  read port B address.
REQ-011 clear  input  1  request bulk clear of all registers.
REQ-012 out_a  output  WIDTH  contents at read_addr_a.
REQ-013 out_b  output  WIDTH  contents at read_addr_b.
REQ-014 busy  output  1  high while a bulk clear is in progress.
REQ-015 written  output  DEPTH  per-register flag, bit i set once register i has been written since last reset/clear.

Function
REQ-016 Write accepted on a rising edge iff enable=1, busy=0 and clear=0; register[write_addr] <= in and written[write_addr] <= 1.
REQ-017 Write with enable=0 SHALL leave all registers and flags unchanged.
REQ-018 Reads SHALL be combinational: out_a/out_b reflect current register contents, zero cycle latency; both ports may address the same register.
REQ-019 FSM states: IDLE, CLEAR. IDLE -> CLEAR on rising edge with clear=1; counter loads 0.
REQ-020 In CLEAR, each cycle zeroes register[counter] and written[counter], then counter increments; CLEAR -> IDLE on the edge that zeroes register DEPTH-1.
REQ-021 busy=1 exactly while state=CLEAR, i.e. DEPTH consecutive cycles.
REQ-022 Simultaneous clear=1 and enable=1 in IDLE: clear wins, write dropped.
REQ-023 enable or clear while busy=1 SHALL be ignored, not queued.
REQ-024 Reads during CLEAR return live contents (already-cleared registers read 0).
REQ-025 Counter SHALL not wrap past DEPTH-1; counter width AW.

Reset
REQ-026 reset_n=0 SHALL immediately, without a clock edge, force all registers to 0, written to 0, state to IDLE, counter to 0, busy to 0.
REQ-027 reset_n asserted mid-clear SHALL abort the clear; after release the block is IDLE and fully zero.
REQ-028 First accepted write is the first rising edge with reset_n=1.

Configuration
REQ-029 Macro REGISTER_FILE_BYPASS_EN: when defined, a read port whose address equals write_addr during an accepted write (REQ-016) SHALL output in combinationally in that same cycle.
REQ-030 Without REGISTER_FILE_BYPASS_EN, read ports show the old value until after the write edge.

Structure
REQ-031 Package register_file_pkg SHALL hold the FSM state type (IDLE, CLEAR) and default WIDTH/DEPTH constants.
REQ-032 Sub-module clear_sequencer SHALL contain the FSM, counter and busy; it outputs clear-strobe plus index to the storage array.

Verification
REQ-033 Reset, then write 45 to addr 3, read_addr_a=3 -> out_a=45 after edge, written=8'b0000_1000.
REQ-034 enable=0, in=5, write_addr=3 -> out_a stays 45; written unchanged.
REQ-035 Write 92 to addr 3 with read_addr_b=3 -> with BYPASS_EN out_b=92 same cycle; without it out_b=45 until edge, then 92.
REQ-036 Fill addrs 0..7 with 10..17, pulse clear -> busy high exactly 8 cycles, register i reads 0 from cycle i+1, written=0 at end; write of 99 during busy ignored.
REQ-037 clear and enable=1 (addr 2, data 7) same edge -> write dropped, clear starts, register 2 ends 0.
REQ-038 Assert reset_n=0 at clear cycle 3 -> outputs zero immediately, busy=0, state IDLE after release.
